// File: rtl/fifo_rd_stream.sv
// Read-side drain engine: pulls words from the async FIFO read port into a 2-entry
// output stage and presents them as a valid/ready stream, with flush and a pop counter.
module fifo_rd_stream #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  R_CLK,
  input  logic                  R_RST,
  input  logic                  EMPTY,
  output logic                  R_EN,
  input  logic [DATA_WIDTH-1:0] O_DATA,
  output logic [DATA_WIDTH-1:0] M_DATA,
  output logic                  M_VALID,
  input  logic                  M_READY,
  input  logic                  FLUSH,
  output logic [1:0]            LEVEL,
  output logic [CNT_WIDTH-1:0]  RD_COUNT
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_FLUSHING = 2'd1;
  localparam logic [1:0] ST_DRAIN    = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_state_d;
  logic [DATA_WIDTH-1:0] r_buf [2];
  logic                  r_head;
  logic                  r_tail;
  logic                  r_inflight;
  logic [1:0]            r_level;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  w_run;
  logic                  w_pop;
  logic                  w_capture;
  logic                  w_issue;
  logic [2:0]            w_occ;

  assign w_run     = (r_state == ST_RUN);
  assign M_VALID   = w_run && (r_level != 2'd0);
  assign M_DATA    = r_buf[r_head];
  assign w_pop     = M_VALID && M_READY;
  assign w_capture = w_run && r_inflight;
  assign LEVEL     = r_level;
  assign RD_COUNT  = r_count;

  // Occupancy after this cycle's pop; reading on a same-cycle pop keeps full throughput.
  assign w_occ = {1'b0, r_level} + {2'b00, r_inflight} - {2'b00, w_pop};

  always_comb begin
    R_EN = 1'b0;
    if (!R_RST) begin
      case (r_state)
        ST_RUN:      R_EN = !EMPTY && (w_occ < 3'd2);
        ST_FLUSHING: R_EN = !EMPTY;
        default:     R_EN = 1'b0;
      endcase
    end
  end

  assign w_issue = R_EN && !EMPTY;

  // Leaving flush with a read still outstanding must swallow that one returning word.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_RUN:      if (FLUSH) w_state_d = ST_FLUSHING;
      ST_FLUSHING: if (!FLUSH) w_state_d = w_issue ? ST_DRAIN : ST_RUN;
      default:     w_state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge R_CLK) begin
    if (R_RST) begin
      r_state    <= ST_RUN;
      r_level    <= 2'd0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
    end else begin
      r_state    <= w_state_d;
      r_inflight <= w_issue;
      if (w_pop) r_count <= r_count + 1'b1;
      if (w_run && FLUSH) begin
        r_level <= 2'd0;
        r_head  <= 1'b0;
        r_tail  <= 1'b0;
      end else begin
        if (w_capture) begin
          r_buf[r_tail] <= O_DATA;
          r_tail        <= ~r_tail;
        end
        if (w_pop) r_head <= ~r_head;
        r_level <= r_level + {1'b0, w_capture} - {1'b0, w_pop};
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a queue models the FIFO, expected words are queued
// at push time and a negedge monitor checks every handshake against them.
module tb_fifo_rd_stream;

  logic       R_CLK = 1'b0;
  logic       R_RST;
  logic       EMPTY;
  logic       R_EN;
  logic [7:0] O_DATA;
  logic [7:0] M_DATA;
  logic       M_VALID;
  logic       M_READY;
  logic       FLUSH;
  logic [1:0] LEVEL;
  logic [15:0] RD_COUNT;

  logic       w_r_en;
  logic [7:0] w_m_data;
  logic       w_m_valid;
  logic [1:0] w_level;
  logic [3:0] w_rd_count;

  always #5 R_CLK = ~R_CLK;

  fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .R_CLK(R_CLK), .R_RST(R_RST), .EMPTY(EMPTY), .R_EN(R_EN), .O_DATA(O_DATA),
    .M_DATA(M_DATA), .M_VALID(M_VALID), .M_READY(M_READY), .FLUSH(FLUSH),
    .LEVEL(LEVEL), .RD_COUNT(RD_COUNT)
  );

  // Narrow-counter twin sees identical inputs, so only its counter width differs.
  fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut_w (
    .R_CLK(R_CLK), .R_RST(R_RST), .EMPTY(EMPTY), .R_EN(w_r_en), .O_DATA(O_DATA),
    .M_DATA(w_m_data), .M_VALID(w_m_valid), .M_READY(M_READY), .FLUSH(FLUSH),
    .LEVEL(w_level), .RD_COUNT(w_rd_count)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  logic empty_mask = 1'b0;

  logic [7:0] fifo_q [$];
  logic [7:0] exp_q  [$];
  int         rd_cyc [$];
  int         pop_cyc [$];
  logic [7:0] pop_dat [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    rd_cyc.delete();
    pop_cyc.delete();
    pop_dat.delete();
  endtask

  task automatic push(input logic [7:0] d, input bit expect_out);
    fifo_q.push_back(d);
    if (expect_out) exp_q.push_back(d);
  endtask

  // One read-clock cycle: inputs already set, FIFO model serves reads at mid-cycle.
  task automatic step();
    logic       issued;
    logic [7:0] word;
    issued = 1'b0;
    word   = 8'hEE;
    EMPTY  = (fifo_q.size() == 0) || empty_mask;
    @(negedge R_CLK);
    check("ren_guard", {30'd0, R_EN && EMPTY, R_EN && R_RST}, 32'd0);
    if (R_EN && !EMPTY) begin
      issued = 1'b1;
      word   = fifo_q.pop_front();
      rd_cyc.push_back(cyc);
    end
    if (M_VALID && M_READY) begin
      pop_cyc.push_back(cyc);
      pop_dat.push_back(M_DATA);
    end
    @(posedge R_CLK);
    #1;
    O_DATA = issued ? word : 8'hEE;
    cyc++;
  endtask

  // Scoreboard monitor and stream-rule checks.
  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic       pf = 1'b0;
  logic       prst = 1'b1;
  logic [7:0] pd = 8'h00;

  always @(negedge R_CLK) begin
    if (M_VALID && M_READY) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL extra_word: got 0x%0h, want no word (cycle %0d)", M_DATA, cyc);
      end else begin
        check("stream_data", {24'd0, M_DATA}, {24'd0, exp_q.pop_front()});
      end
    end
    if (pv && !pr && !pf && !prst) begin
      check("hold_valid", {31'd0, M_VALID}, 32'd1);
      check("hold_data", {24'd0, M_DATA}, {24'd0, pd});
    end
    assert (!(dut.r_inflight && LEVEL == 2'd2 && M_VALID && M_READY))
    else begin
      n_miss++;
      $display("FAIL capture_pop_full: got capture+pop at LEVEL 2, want unreachable");
    end
    pv   = M_VALID;
    pr   = M_READY;
    pf   = FLUSH;
    prst = R_RST;
    pd   = M_DATA;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int n;
    R_RST   = 1'b1;
    EMPTY   = 1'b1;
    M_READY = 1'b0;
    FLUSH   = 1'b0;
    O_DATA  = 8'h00;
    @(posedge R_CLK);
    #1;
    step();
    step();
    check("rst_valid", {31'd0, M_VALID}, 32'd0);
    check("rst_level", {30'd0, LEVEL}, 32'd0);
    check("rst_count", {16'd0, RD_COUNT}, 32'd0);
    check("rst_data", {24'd0, M_DATA}, 32'd0);
    check("rst_ren", {31'd0, R_EN}, 32'd0);
    R_RST = 1'b0;

    // Reset arriving while a read is outstanding drops that word.
    clear_logs();
    push(8'h99, 1'b1);
    M_READY = 1'b1;
    step();
    check("midrd_issue", rd_cyc.size(), 32'd1);
    R_RST = 1'b1;
    step();
    R_RST = 1'b0;
    exp_q.delete();
    check("midrd_valid", {31'd0, M_VALID}, 32'd0);
    check("midrd_level", {30'd0, LEVEL}, 32'd0);
    check("midrd_count", {16'd0, RD_COUNT}, 32'd0);
    step();
    step();
    check("midrd_valid2", {31'd0, M_VALID}, 32'd0);
    check("midrd_level2", {30'd0, LEVEL}, 32'd0);

    // Stream order and latency.
    clear_logs();
    base = cyc;
    push(8'h11, 1'b1);
    push(8'h22, 1'b1);
    push(8'h33, 1'b1);
    push(8'h44, 1'b1);
    repeat (8) step();
    check("order_reads", rd_cyc.size(), 32'd4);
    check("order_pops", pop_dat.size(), 32'd4);
    if (rd_cyc.size() > 0) check("order_first_rd", rd_cyc[0], base);
    if (pop_dat.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("order_cycle", pop_cyc[i], base + 2 + i);
      end
    end
    check("order_count", {16'd0, RD_COUNT}, 32'd4);
    check("order_count_w", {28'd0, w_rd_count}, 32'd4);

    // Back-pressure: two reads outstanding at most, head held stable.
    clear_logs();
    M_READY = 1'b0;
    for (int i = 0; i < 10; i++) push(8'h50 + 8'(i), 1'b1);
    repeat (6) step();
    check("bp_reads", rd_cyc.size(), 32'd2);
    check("bp_level", {30'd0, LEVEL}, 32'd2);
    check("bp_valid", {31'd0, M_VALID}, 32'd1);
    check("bp_head", {24'd0, M_DATA}, 32'h50);
    clear_logs();
    M_READY = 1'b1;
    repeat (14) step();
    check("bp_pops", pop_dat.size(), 32'd10);
    if (pop_dat.size() == 10) check("bp_rate", pop_cyc[9] - pop_cyc[0], 32'd9);
    check("bp_count", {16'd0, RD_COUNT}, 32'd14);
    check("bp_count_w", {28'd0, w_rd_count}, 32'd14);

    // Empty toggling every cycle with random ready.
    clear_logs();
    for (int i = 0; i < 8; i++) push(8'h60 + 8'(i), 1'b1);
    n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      empty_mask = cyc[0];
      M_READY    = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    empty_mask = 1'b0;
    M_READY    = 1'b1;
    check("ep_drained", exp_q.size(), 32'd0);
    check("ep_pops", pop_dat.size(), 32'd8);
    check("ep_level", {30'd0, LEVEL}, 32'd0);
    check("ep_count", {16'd0, RD_COUNT}, 32'd22);
    check("ep_count_w", {28'd0, w_rd_count}, 32'd6);

    // Flush with a full stage and a backed-up FIFO.
    clear_logs();
    M_READY = 1'b0;
    for (int i = 0; i < 5; i++) push(8'h70 + 8'(i), 1'b1);
    repeat (4) step();
    check("fl_prefill", {30'd0, LEVEL}, 32'd2);
    for (int i = 5; i < 11; i++) push(8'h70 + 8'(i), 1'b0);
    FLUSH = 1'b1;
    exp_q.delete();
    n = 0;
    while ((n < 3 || fifo_q.size() != 0) && n < 40) begin
      step();
      check("fl_valid", {31'd0, M_VALID}, 32'd0);
      n++;
    end
    check("fl_fifo_empty", fifo_q.size(), 32'd0);
    FLUSH   = 1'b0;
    M_READY = 1'b1;
    repeat (4) step();
    check("fl_after_valid", {31'd0, M_VALID}, 32'd0);
    check("fl_after_level", {30'd0, LEVEL}, 32'd0);
    clear_logs();
    push(8'hA5, 1'b1);
    repeat (4) step();
    check("fl_new_pops", pop_dat.size(), 32'd1);
    if (pop_dat.size() > 0) check("fl_new_word", {24'd0, pop_dat[0]}, 32'hA5);
    check("fl_count", {16'd0, RD_COUNT}, 32'd23);
    check("fl_count_w", {28'd0, w_rd_count}, 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
